// File: rtl/prefetcher_stride_detector_if.sv
// prefetcher_stride_detector_if: observed AR request bus plus the learned-stride result bus
interface prefetcher_stride_detector_if #(
  parameter int ADDR_BITS   = 64,
  parameter int TID_WIDTH   = 8,
  parameter int STRIDE_BITS = 16,
  parameter int CONF_WIDTH  = 2
);
  logic                   obs_valid;
  logic [ADDR_BITS-1:0]   obs_addr;
  logic [TID_WIDTH-1:0]   obs_id;
  logic                   stride_valid;
  logic [STRIDE_BITS-1:0] stride;
  logic [TID_WIDTH-1:0]   stride_id;
  logic [ADDR_BITS-1:0]   next_addr;
  logic                   stride_changed;
  logic [CONF_WIDTH-1:0]  conf;
  modport master (
    output obs_valid, obs_addr, obs_id,
    input  stride_valid, stride, stride_id, next_addr, stride_changed, conf
  );
  modport slave (
    input  obs_valid, obs_addr, obs_id,
    output stride_valid, stride, stride_id, next_addr, stride_changed, conf
  );
endinterface

// File: rtl/prefetcher_stride_detector.sv
// prefetcher_stride_detector: learns a constant address stride for one AXI ID inside the CR-space window
module prefetcher_stride_detector #(
  parameter int ADDR_BITS      = 64,
  parameter int TID_WIDTH      = 8,
  parameter int STRIDE_BITS    = 16,
  parameter int CONF_WIDTH     = 2,
  parameter int LOCK_THRESHOLD = 2,
  parameter int TIMEOUT_WIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     en,
  input  logic                     flush,
  input  logic [ADDR_BITS-1:0]     crs_bar,
  input  logic [ADDR_BITS-1:0]     crs_limit,
  input  logic [TIMEOUT_WIDTH-1:0] crs_timeout,
  prefetcher_stride_detector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FIRST, TRAIN, LOCKED} state_t;
  state_t                   state, state_d;
  logic [ADDR_BITS-1:0]     last_addr, last_d;
  logic [STRIDE_BITS-1:0]   stride_q, stride_d;
  logic [TID_WIDTH-1:0]     id_q, id_d;
  logic [CONF_WIDTH-1:0]    conf_q, conf_d;
  logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_d;
  logic                     changed_q, changed_d;
  logic [ADDR_BITS-1:0]     delta, stride_ext;
  logic [CONF_WIDTH:0]      conf_inc;
  logic                     qual, match, dvalid, dsame, expire;
  assign stride_ext = {{(ADDR_BITS-STRIDE_BITS){stride_q[STRIDE_BITS-1]}}, stride_q};
  assign delta      = bus.obs_addr - last_addr;
  assign qual       = bus.obs_valid && bus.obs_addr >= crs_bar && bus.obs_addr <= crs_limit;
  assign match      = qual && state != IDLE && bus.obs_id == id_q;
  // delta must be nonzero and representable as a signed STRIDE_BITS value
  assign dvalid     = delta != '0 && (&delta[ADDR_BITS-1:STRIDE_BITS-1] || ~|delta[ADDR_BITS-1:STRIDE_BITS-1]);
  assign dsame      = delta == stride_ext;
  assign conf_inc   = {1'b0, conf_q} + 1'b1;
  assign expire     = crs_timeout != '0 && tcnt == crs_timeout;
  always_comb begin
    state_d   = state;
    last_d    = last_addr;
    stride_d  = stride_q;
    id_d      = id_q;
    conf_d    = conf_q;
    tcnt_d    = tcnt;
    changed_d = 1'b0;
    if (flush) begin
      state_d  = IDLE;
      conf_d   = '0;
      stride_d = '0;
      tcnt_d   = '0;
    end else if (en) begin
      if (state == IDLE) begin
        if (qual) begin
          last_d  = bus.obs_addr;
          id_d    = bus.obs_id;
          tcnt_d  = '0;
          state_d = FIRST;
        end
      end else if (match) begin
        last_d = bus.obs_addr;
        tcnt_d = '0;
        case (state)
          FIRST: if (dvalid) begin
            stride_d = delta[STRIDE_BITS-1:0];
            conf_d   = '0;
            state_d  = TRAIN;
          end
          TRAIN: if (dsame) begin
            conf_d  = conf_inc[CONF_WIDTH-1:0];
            state_d = conf_inc >= (CONF_WIDTH+1)'(LOCK_THRESHOLD) ? LOCKED : TRAIN;
          end else if (dvalid) begin
            stride_d = delta[STRIDE_BITS-1:0];
            conf_d   = '0;
          end else begin
            state_d = FIRST;
          end
          LOCKED: if (dsame) begin
            conf_d = &conf_q ? conf_q : conf_inc[CONF_WIDTH-1:0];
          end else begin
            changed_d = 1'b1;
            conf_d    = '0;
            stride_d  = dvalid ? delta[STRIDE_BITS-1:0] : stride_q;
            state_d   = dvalid ? TRAIN : FIRST;
          end
          default: ;
        endcase
      end else begin
        tcnt_d  = expire ? '0 : tcnt + 1'b1;
        state_d = expire ? IDLE : state;
      end
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      last_addr <= '0;
      stride_q  <= '0;
      id_q      <= '0;
      conf_q    <= '0;
      tcnt      <= '0;
      changed_q <= 1'b0;
    end else begin
      state     <= state_d;
      last_addr <= last_d;
      stride_q  <= stride_d;
      id_q      <= id_d;
      conf_q    <= conf_d;
      tcnt      <= tcnt_d;
      changed_q <= changed_d;
    end
  end
  assign bus.stride_valid   = state == LOCKED;
  assign bus.stride         = stride_q;
  assign bus.stride_id      = id_q;
  assign bus.next_addr      = last_addr + stride_ext;
  assign bus.stride_changed = changed_q;
  assign bus.conf           = conf_q;
endmodule

// File: tb/tb_prefetcher_stride_detector.sv
// tb_prefetcher_stride_detector: directed scenario tests for the stride detector
module tb_prefetcher_stride_detector;
  logic        clk = 1'b0;
  logic        resetN, en, flush;
  logic [63:0] crs_bar, crs_limit;
  logic [9:0]  crs_timeout;
  int          n_checks = 0;
  int          n_fail = 0;
  prefetcher_stride_detector_if bus ();
  prefetcher_stride_detector dut (
    .clk(clk), .resetN(resetN), .en(en), .flush(flush),
    .crs_bar(crs_bar), .crs_limit(crs_limit), .crs_timeout(crs_timeout),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic obs(input logic [63:0] a, input logic [7:0] id);
    bus.obs_valid = 1'b1;
    bus.obs_addr  = a;
    bus.obs_id    = id;
    @(posedge clk); #1;
    bus.obs_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    resetN = 1'b0; en = 1'b1; flush = 1'b0;
    bus.obs_valid = 1'b0; bus.obs_addr = '0; bus.obs_id = '0;
    crs_bar = 64'h1000; crs_limit = 64'hFFFF; crs_timeout = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%0b changed=%0b want 0 0", bus.stride_valid, bus.stride_changed); end
    n_checks++; if (bus.stride !== 16'h0 || bus.conf !== 2'd0 || bus.stride_id !== 8'h0) begin n_fail++; $display("FAIL reset_regs: stride=%0h conf=%0d id=%0h want 0 0 0", bus.stride, bus.conf, bus.stride_id); end
    n_checks++; if (bus.next_addr !== 64'h0) begin n_fail++; $display("FAIL reset_next: got %0h want 0", bus.next_addr); end
    resetN = 1'b1;
    idle(1);
  endtask
  task automatic test_lock;
    obs(64'h1000, 8'd3);
    obs(64'h1040, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.stride !== 16'h40 || bus.conf !== 2'd0) begin n_fail++; $display("FAIL lock_train: valid=%0b stride=%0h conf=%0d want 0 40 0", bus.stride_valid, bus.stride, bus.conf); end
    obs(64'h1080, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.conf !== 2'd1) begin n_fail++; $display("FAIL lock_conf1: valid=%0b conf=%0d want 0 1", bus.stride_valid, bus.conf); end
    obs(64'h10C0, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.stride !== 16'h40 || bus.conf !== 2'd2) begin n_fail++; $display("FAIL lock_locked: valid=%0b stride=%0h conf=%0d want 1 40 2", bus.stride_valid, bus.stride, bus.conf); end
    n_checks++; if (bus.next_addr !== 64'h1100 || bus.stride_id !== 8'd3) begin n_fail++; $display("FAIL lock_next: next=%0h id=%0d want 1100 3", bus.next_addr, bus.stride_id); end
  endtask
  task automatic test_break;
    obs(64'h1200, 8'd3);
    n_checks++; if (bus.stride_changed !== 1'b1 || bus.stride_valid !== 1'b0) begin n_fail++; $display("FAIL break_pulse: changed=%0b valid=%0b want 1 0", bus.stride_changed, bus.stride_valid); end
    n_checks++; if (bus.stride !== 16'h140 || bus.conf !== 2'd0) begin n_fail++; $display("FAIL break_stride: stride=%0h conf=%0d want 140 0", bus.stride, bus.conf); end
    idle(1);
    n_checks++; if (bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL break_one_cycle: changed=%0b want 0", bus.stride_changed); end
  endtask
  task automatic test_filter_and_saturate;
    obs(64'h1340, 8'd3);
    obs(64'h1480, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.conf !== 2'd2) begin n_fail++; $display("FAIL relock: valid=%0b conf=%0d want 1 2", bus.stride_valid, bus.conf); end
    obs(64'h15C0, 8'd5);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.conf !== 2'd2 || bus.next_addr !== 64'h15C0 || bus.stride_id !== 8'd3) begin n_fail++; $display("FAIL filter_id: valid=%0b conf=%0d next=%0h id=%0d want 1 2 15c0 3", bus.stride_valid, bus.conf, bus.next_addr, bus.stride_id); end
    obs(64'h20000, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.conf !== 2'd2 || bus.next_addr !== 64'h15C0 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL filter_window: valid=%0b conf=%0d next=%0h changed=%0b want 1 2 15c0 0", bus.stride_valid, bus.conf, bus.next_addr, bus.stride_changed); end
    obs(64'h15C0, 8'd3);
    n_checks++; if (bus.conf !== 2'd3 || bus.next_addr !== 64'h1700) begin n_fail++; $display("FAIL locked_inc: conf=%0d next=%0h want 3 1700", bus.conf, bus.next_addr); end
    obs(64'h1700, 8'd3);
    n_checks++; if (bus.conf !== 2'd3 || bus.next_addr !== 64'h1840 || bus.stride_valid !== 1'b1) begin n_fail++; $display("FAIL locked_sat: conf=%0d next=%0h valid=%0b want 3 1840 1", bus.conf, bus.next_addr, bus.stride_valid); end
  endtask
  task automatic test_enable;
    en = 1'b0;
    obs(64'h1900, 8'd3);
    en = 1'b1;
    n_checks++; if (bus.stride_changed !== 1'b0 || bus.stride_valid !== 1'b1 || bus.next_addr !== 64'h1840 || bus.conf !== 2'd3) begin n_fail++; $display("FAIL enable_hold: changed=%0b valid=%0b next=%0h conf=%0d want 0 1 1840 3", bus.stride_changed, bus.stride_valid, bus.next_addr, bus.conf); end
  endtask
  task automatic test_invalid_delta;
    crs_limit = '1;
    obs(64'h100000, 8'd3);
    n_checks++; if (bus.stride_changed !== 1'b1 || bus.stride_valid !== 1'b0 || bus.conf !== 2'd0) begin n_fail++; $display("FAIL invalid_break: changed=%0b valid=%0b conf=%0d want 1 0 0", bus.stride_changed, bus.stride_valid, bus.conf); end
    n_checks++; if (bus.stride !== 16'h140 || bus.next_addr !== 64'h100140) begin n_fail++; $display("FAIL invalid_keep: stride=%0h next=%0h want 140 100140", bus.stride, bus.next_addr); end
    obs(64'h100040, 8'd3);
    n_checks++; if (bus.stride !== 16'h40 || bus.conf !== 2'd0 || bus.stride_valid !== 1'b0) begin n_fail++; $display("FAIL first_to_train: stride=%0h conf=%0d valid=%0b want 40 0 0", bus.stride, bus.conf, bus.stride_valid); end
  endtask
  task automatic test_flush;
    flush = 1'b1;
    obs(64'h100080, 8'd3);
    flush = 1'b0;
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.conf !== 2'd0 || bus.stride !== 16'h0 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL flush_clear: valid=%0b conf=%0d stride=%0h changed=%0b want 0 0 0 0", bus.stride_valid, bus.conf, bus.stride, bus.stride_changed); end
    n_checks++; if (bus.next_addr !== 64'h100040) begin n_fail++; $display("FAIL flush_drop: next=%0h want 100040", bus.next_addr); end
  endtask
  task automatic test_negative;
    crs_bar = '0; crs_limit = '1;
    obs(64'h40, 8'd3);
    obs(64'h0, 8'd3);
    n_checks++; if (bus.stride !== 16'hFFC0 || bus.conf !== 2'd0 || bus.next_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin n_fail++; $display("FAIL neg_train: stride=%0h conf=%0d next=%0h want ffc0 0 ffffffffffffffc0", bus.stride, bus.conf, bus.next_addr); end
    obs(64'hFFFF_FFFF_FFFF_FFC0, 8'd3);
    n_checks++; if (bus.conf !== 2'd1 || bus.next_addr !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL neg_wrap: conf=%0d next=%0h want 1 ffffffffffffff80", bus.conf, bus.next_addr); end
    obs(64'hFFFF_FFFF_FFFF_FF80, 8'd3);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.stride !== 16'hFFC0 || bus.conf !== 2'd2) begin n_fail++; $display("FAIL neg_lock: valid=%0b stride=%0h conf=%0d want 1 ffc0 2", bus.stride_valid, bus.stride, bus.conf); end
  endtask
  task automatic test_timeout;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    crs_bar = 64'h1000; crs_limit = 64'hFFFF; crs_timeout = 10'd4;
    obs(64'h1000, 8'd3);
    obs(64'h1040, 8'd3);
    obs(64'h1080, 8'd3);
    obs(64'h10C0, 8'd3);
    obs(64'h1200, 8'd5);
    obs(64'h1300, 8'd5);
    idle(2);
    n_checks++; if (bus.stride_valid !== 1'b1 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL timeout_before: valid=%0b changed=%0b want 1 0", bus.stride_valid, bus.stride_changed); end
    idle(1);
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL timeout_expire: valid=%0b changed=%0b want 0 0", bus.stride_valid, bus.stride_changed); end
    crs_timeout = '0;
  endtask
  task automatic test_async_reset;
    obs(64'h2000, 8'd3);
    obs(64'h2040, 8'd3);
    obs(64'h2080, 8'd3);
    n_checks++; if (bus.conf !== 2'd1 || bus.stride !== 16'h40) begin n_fail++; $display("FAIL pre_reset_train: conf=%0d stride=%0h want 1 40", bus.conf, bus.stride); end
    @(negedge clk);
    resetN = 1'b0;
    #1;
    n_checks++; if (bus.stride_valid !== 1'b0 || bus.stride !== 16'h0 || bus.conf !== 2'd0 || bus.stride_id !== 8'h0 || bus.next_addr !== 64'h0 || bus.stride_changed !== 1'b0) begin n_fail++; $display("FAIL async_reset: valid=%0b stride=%0h conf=%0d id=%0h next=%0h changed=%0b want all 0", bus.stride_valid, bus.stride, bus.conf, bus.stride_id, bus.next_addr, bus.stride_changed); end
    @(negedge clk);
    resetN = 1'b1;
    obs(64'h3000, 8'd7);
    obs(64'h3080, 8'd7);
    n_checks++; if (bus.stride_id !== 8'd7 || bus.stride !== 16'h80 || bus.conf !== 2'd0 || bus.stride_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_train: id=%0d stride=%0h conf=%0d valid=%0b want 7 80 0 0", bus.stride_id, bus.stride, bus.conf, bus.stride_valid); end
  endtask
  initial begin
    test_reset;
    test_lock;
    test_break;
    test_filter_and_saturate;
    test_enable;
    test_invalid_delta;
    test_flush;
    test_negative;
    test_timeout;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
